multicycle_cu: RTL and testbench
================================

# multicycle_cu

Parametrised multicycle control unit for the ARM-subset processor. It generalises the single-cycle decoder into a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It tolerates variable-latency memory through a ready handshake and owns the NZCV flag register and condition evaluation. It drives the shared-datapath multicycle core, one instruction in flight.

## Interface
- ALU_W, 4, width of alu_control
- MEM_WAIT_EN, 1, 1: memory states hold until mem_ready; 0: mem_ready ignored, treated as 1
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cond  in  4  instr[31:28]
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20]
- rd  in  4  instr[15:12]
- sh  in  2  instr[6:5]
- alu_flags  in  4  NZCV from ALU, current cycle
- mem_ready  in  1  memory completes access this cycle
- pc_write, ir_write, reg_write, mem_write  out  1 each  write enables
- adr_src  out  1  0: PC, 1: ALU result register
- alu_src_a  out  1  0: Rn, 1: PC
- alu_src_b  out  2  00: Rm/shifted, 01: extended imm, 10: constant 4
- result_src  out  2  00: ALUOut, 01: read data, 10: ALU result
- imm_src, reg_src  out  2 each  extender select; register-address select
- alu_control  out  ALU_W  ALU operation
- sh_src, mov_src, mvn_src  out  1 each  shifter/move path selects
- state  out  4  current state, debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: adr_src=0, a=1, b=10, add, result_src=10. ir_write and pc_write only in a cycle with mem_ready=1. Otherwise hold.
- DECODE: a=1, b=10, add. Latch cond_ex_q = condition(cond, flags_q). Next state:
  - op=01: MEMADR
  - op=10: BRANCH
  - op=00: EXECI if funct[5], else EXECR
  - op=11: FETCH, a NOP with no writes
- MEMADR: a=0, b=01, add. Next MEMREAD if funct[0], else MEMWRITE.
- MEMREAD: adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex_q. pc_write=cond_ex_q&(rd==15).
- MEMWRITE: adr_src=1, mem_write=cond_ex_q while in state. Leave to FETCH on mem_ready.
- EXECR/EXECI: decoded alu_control, b=00/01. Flags update at exit edge; next ALUWB.
- ALUWB: result_src=00, reg_write=cond_ex_q&~no_write. pc_write=cond_ex_q&~no_write&(rd==15).
- BRANCH: a=0, b=01, add, result_src=10, pc_write=cond_ex_q. Next FETCH.
- reg_src[0]=branch, reg_src[1]=store.
- imm_src: 00 DP, 01 mem, 10 branch, 11 shift-class with funct[5]=0.
- ALU decode, funct[4:1] to alu_control:
  - ADD/CMN 0000, SUB/CMP 0001, AND/TST 0010, ORR 0011, EOR/TEQ 0100, MVN 0101
  - 1101 shift-class by sh: LSL 1000, LSR 1001, ASR 1010, ROR 1011
  - non-DP states: 0000. Upper bits zero-extended when ALU_W>4.
- no_write: TST/TEQ/CMP/CMN.
- sh_src: shift-class or MVN. mov_src/mvn_src additionally require funct[5].
- Flags, NZCV register:
  - NZ written if cond_ex_q&funct[0]
  - CV written if also alu_control[3]=0
- Condition: standard ARM EQ..AL. 1111 evaluates false.

## Timing
- Reset: state=FETCH, flags_q=0000, cond_ex_q=0. Every write enable is 0 while reset is high. Reset mid-instruction aborts with no writes; fetch restarts next cycle.
- Zero-wait latency: DP 4, LDR 5, STR 4, B 3, undefined 2 cycles. Each FETCH/MEMREAD/MEMWRITE cycle with mem_ready=0 adds one cycle.
- cond_ex_q is frozen from DECODE. An S-instruction's own flag update never affects its writeback.
- mem_ready high on state entry completes in that cycle. There is no mem_ready pulse memory.

## Structure
- Package cu_pkg: state enum, op encodings, alu_control constants, cond codes.
- Sub-module cu_alu_decoder: combinational funct/sh/op to alu_control, no_write, sh/mov/mvn selects, flag-write mask. Reused by the single-cycle core.
- Top module: FSM, flags register, condition logic, output decode.

## Test plan
- ADDS R1 (funct=101001), flags 0 -> states F,D,EXECI,ALUWB. reg_write=1 in cycle 4; flags_q updates at EXECI exit.
- LDR with mem_ready low 3 cycles in MEMREAD -> 8 total cycles, one reg_write pulse.
- BEQ with Z=0 -> BRANCH reached, pc_write=0. With Z=1 -> pc_write=1 in cycle 3.
- CMP then MOVEQ R15 -> CMP reg_write=0; MOVEQ asserts pc_write in ALUWB.
- Reset asserted during MEMWRITE with mem_write high -> mem_write=0 same cycle; state=FETCH next edge.
- LSR, funct[4:1]=1101, sh=01 -> alu_control=1001, flag CV write suppressed.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Also holds the ARM condition evaluator used at decode.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MVN = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic cond_met(
    input logic [3:0] c,
    input logic [3:0] nzcv
  );
    logic n, z, cy, v, r;
    {n, z, cy, v} = nzcv;
    r = 1'b0;
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = cy;
      COND_CC: r = ~cy;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cy & ~z;
      COND_LS: r = ~cy | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cu_alu_decoder.sv
// Combinational data-processing decoder: funct/sh to ALU op,
// move/shift path selects and the NZ/CV flag-write mask.
module cu_alu_decoder
  import cu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [1:0] sh,
  output logic [3:0] alu_ctl,
  output logic       no_write,
  output logic       sh_src,
  output logic       mov_src,
  output logic       mvn_src,
  output logic [1:0] flag_w
);

  logic [3:0] cmd;
  logic       dp;
  logic       is_shift;
  logic       is_mvn;

  assign cmd = funct[4:1];
  assign dp  = (op == OP_DP);

  always_comb begin
    alu_ctl  = ALU_ADD;
    no_write = 1'b0;
    is_shift = 1'b0;
    is_mvn   = 1'b0;
    if (dp) begin
      case (cmd)
        CMD_ADD: alu_ctl = ALU_ADD;
        CMD_CMN: begin
          alu_ctl  = ALU_ADD;
          no_write = 1'b1;
        end
        CMD_SUB: alu_ctl = ALU_SUB;
        CMD_CMP: begin
          alu_ctl  = ALU_SUB;
          no_write = 1'b1;
        end
        CMD_AND: alu_ctl = ALU_AND;
        CMD_TST: begin
          alu_ctl  = ALU_AND;
          no_write = 1'b1;
        end
        CMD_ORR: alu_ctl = ALU_ORR;
        CMD_EOR: alu_ctl = ALU_EOR;
        CMD_TEQ: begin
          alu_ctl  = ALU_EOR;
          no_write = 1'b1;
        end
        CMD_MVN: begin
          alu_ctl = ALU_MVN;
          is_mvn  = 1'b1;
        end
        CMD_MOV: begin
          alu_ctl  = {2'b10, sh};
          is_shift = 1'b1;
        end
        default: alu_ctl = ALU_ADD;
      endcase
    end
  end

  assign sh_src  = is_shift | is_mvn;
  assign mov_src = is_shift & funct[5];
  assign mvn_src = is_mvn & funct[5];

  // shifter ops own the carry, so CV is left alone for them
  assign flag_w[1] = dp & funct[0];
  assign flag_w[0] = dp & funct[0] & ~alu_ctl[3];

endmodule

// File: rtl/multicycle_cu.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with NZCV flag register and per-instruction condition latch.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALU_W       = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cond,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic [1:0]       sh,
  input  logic [3:0]       alu_flags,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [1:0]       reg_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             sh_src,
  output logic             mov_src,
  output logic             mvn_src,
  output logic [3:0]       state
);

  state_t     st;
  state_t     st_nx;
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       rdy;
  logic       exec;
  logic       alu_sel;
  logic       pc_w;
  logic       ir_w;
  logic       reg_w;
  logic       mem_w;
  logic [3:0] dec_alu;
  logic       no_write;
  logic [1:0] flag_w;
  logic       pc_dst;

  cu_alu_decoder u_dec (
    .op       (op),
    .funct    (funct),
    .sh       (sh),
    .alu_ctl  (dec_alu),
    .no_write (no_write),
    .sh_src   (sh_src),
    .mov_src  (mov_src),
    .mvn_src  (mvn_src),
    .flag_w   (flag_w)
  );

  assign rdy    = mem_ready | ~MEM_WAIT_EN;
  assign exec   = (st == S_EXECR) || (st == S_EXECI);
  assign pc_dst = (rd == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_FETCH;
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == S_DECODE)
        cond_ex_q <= cond_met(cond, flags_q);
      if (exec && cond_ex_q) begin
        if (flag_w[1])
          flags_q[3:2] <= alu_flags[3:2];
        if (flag_w[0])
          flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

  always_comb begin
    st_nx      = st;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_sel    = 1'b0;
    unique case (st)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (rdy) begin
          ir_w  = 1'b1;
          pc_w  = 1'b1;
          st_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (op)
          OP_MEM: st_nx = S_MEMADR;
          OP_BR:  st_nx = S_BRANCH;
          OP_DP:  st_nx = funct[5] ? S_EXECI : S_EXECR;
          OP_UND: st_nx = S_FETCH;
          default: st_nx = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        st_nx = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (rdy)
          st_nx = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w = cond_ex_q;
        pc_w  = cond_ex_q & pc_dst;
        st_nx = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = cond_ex_q;
        if (rdy)
          st_nx = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b = (st == S_EXECI) ? 2'b01 : 2'b00;
        alu_sel   = 1'b1;
        st_nx     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = cond_ex_q & ~no_write;
        pc_w  = cond_ex_q & ~no_write & pc_dst;
        st_nx = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w  = cond_ex_q;
        st_nx = S_FETCH;
      end
      default: st_nx = S_FETCH;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_DP: begin
        if (funct[4:1] == CMD_MOV && !funct[5])
          imm_src = 2'b11;
      end
      OP_MEM:  imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      default: imm_src = 2'b00;
    endcase
  end

  assign reg_src[0] = (op == OP_BR);
  assign reg_src[1] = (op == OP_MEM) & ~funct[0];

  assign alu_control =
    ALU_W'(alu_sel ? dec_alu : ALU_ADD);

  // a reset cycle must never commit anything
  assign pc_write  = pc_w & ~reset;
  assign ir_write  = ir_w & ~reset;
  assign reg_write = reg_w & ~reset;
  assign mem_write = mem_w & ~reset;

  assign state = st;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench: an instruction-level model plans each cycle,
// a negedge monitor compares DUT controls against the plan.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cond = '0;
  logic [1:0] op = '0;
  logic [5:0] funct = '0;
  logic [3:0] rd = '0;
  logic [1:0] sh = '0;
  logic [3:0] alu_flags = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src;
  logic [3:0] alu_control;
  logic       sh_src, mov_src, mvn_src;
  logic [3:0] state;

  multicycle_cu #(.ALU_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op),
    .funct(funct), .rd(rd), .sh(sh),
    .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write),
    .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .reg_src(reg_src),
    .alu_control(alu_control), .sh_src(sh_src),
    .mov_src(mov_src), .mvn_src(mvn_src), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, irw, rw, mw, adr, a;
    logic [1:0] b, res, imm, rsrc;
    logic [3:0] alu;
    logic shs, movs, mvns;
  } obs_t;

  typedef struct {
    logic rst, rdy;
    logic [3:0] cond, rd, af;
    logic [1:0] op, sh;
    logic [5:0] funct;
    obs_t e, m;
    int ph;
  } item_t;

  typedef struct { obs_t e, m; int ph; } exp_t;

  localparam int PH_RST = 0, PH_F = 1, PH_D = 2;
  localparam int PH_MA = 3, PH_MR = 4, PH_MWB = 5;
  localparam int PH_MW = 6, PH_EX = 7, PH_AWB = 8;
  localparam int PH_BR = 9;

  item_t plan[$];
  exp_t  sb[$];
  obs_t  obs;
  int    n_chk = 0, n_fail = 0, cyc = 0;
  logic [3:0] flags_m = '0;
  item_t cur;
  int    cyc_idx, abort_at;
  bit    aborted;
  int    fw_fetch = -1, fw_mem = -1, force_af = -1;

  assign obs = {pc_write, ir_write, reg_write, mem_write,
                adr_src, alu_src_a, alu_src_b, result_src,
                imm_src, reg_src, alu_control,
                sh_src, mov_src, mvn_src};

  function automatic string ph_name(int p);
    case (p)
      PH_RST: return "reset";
      PH_F:   return "fetch";
      PH_D:   return "decode";
      PH_MA:  return "memadr";
      PH_MR:  return "memread";
      PH_MWB: return "memwb";
      PH_MW:  return "memwrite";
      PH_EX:  return "exec";
      PH_AWB: return "aluwb";
      default: return "branch";
    endcase
  endfunction

  // ARM rule: pair base test, odd code inverts, 1111 never
  function automatic bit ref_cond(logic [3:0] c, logic [3:0] fl);
    bit n, z, cy, v, base;
    {n, z, cy, v} = fl;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] ref_alu(logic [3:0] cmd,
                                         logic [1:0] s);
    case (cmd)
      4'd4, 4'd11: return 4'd0;
      4'd2, 4'd10: return 4'd1;
      4'd0, 4'd8:  return 4'd2;
      4'd12:       return 4'd3;
      4'd1, 4'd9:  return 4'd4;
      4'd15:       return 4'd5;
      4'd13:       return {2'b10, s};
      default:     return 4'd0;
    endcase
  endfunction

  function automatic int pick_wait(int fw);
    if (fw >= 0) return fw;
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(1, 3));
    return 0;
  endfunction

  function automatic obs_t wmask();
    obs_t m;
    m = '0;
    {m.pcw, m.irw, m.rw, m.mw} = 4'hf;
    m.alu = 4'hf;
    return m;
  endfunction

  task automatic push_rst();
    item_t it;
    it = cur;
    it.rst = 1'b1;
    it.rdy = 1'($urandom);
    it.af = 4'($urandom);
    it.e = '0;
    it.m = '0;
    {it.m.pcw, it.m.irw, it.m.rw, it.m.mw} = 4'hf;
    it.ph = PH_RST;
    plan.push_back(it);
    flags_m = '0;
  endtask

  task automatic step(input int ph, input logic rdy,
                      input obs_t e, input obs_t m,
                      output logic [3:0] af);
    item_t it;
    af = (force_af >= 0) ? 4'(force_af) : 4'($urandom);
    if (aborted) return;
    if (cyc_idx == abort_at) begin
      push_rst();
      aborted = 1'b1;
    end else begin
      it = cur;
      it.rst = 1'b0;
      it.rdy = rdy;
      it.af = af;
      it.e = e;
      it.m = m;
      it.ph = ph;
      plan.push_back(it);
    end
    cyc_idx++;
  endtask

  task automatic run_instr(input logic [3:0] c,
                           input logic [1:0] o,
                           input logic [5:0] f,
                           input logic [3:0] r,
                           input logic [1:0] s,
                           input int ab);
    obs_t e, m;
    logic [3:0] af, alu, cmd;
    bit ce, nw, is_mov, is_mvn;
    int w;
    cur.cond = c; cur.op = o; cur.funct = f;
    cur.rd = r; cur.sh = s;
    cyc_idx = 0; abort_at = ab; aborted = 1'b0;
    ce = ref_cond(c, flags_m);
    cmd = f[4:1];
    alu = ref_alu(cmd, s);
    nw = (cmd inside {4'd8, 4'd9, 4'd10, 4'd11});
    is_mov = (cmd == 4'd13);
    is_mvn = (cmd == 4'd15);
    // fetch: PC+4 through ALU, waits on memory
    e = '0; m = wmask();
    e.a = 1'b1; e.b = 2'b10; e.res = 2'b10;
    m.adr = 1'b1; m.a = 1'b1; m.b = 2'b11; m.res = 2'b11;
    w = pick_wait(fw_fetch);
    repeat (w) step(PH_F, 1'b0, e, m, af);
    e.pcw = 1'b1; e.irw = 1'b1;
    step(PH_F, 1'b1, e, m, af);
    e = '0; m = wmask();
    e.a = 1'b1; e.b = 2'b10;
    m.a = 1'b1; m.b = 2'b11;
    if (o != 2'b11) begin
      e.imm = (o == 2'b01) ? 2'b01 :
              (o == 2'b10) ? 2'b10 :
              (is_mov && !f[5]) ? 2'b11 : 2'b00;
      e.rsrc = {o == 2'b01 && !f[0], o == 2'b10};
      m.imm = 2'b11; m.rsrc = 2'b11;
    end
    step(PH_D, 1'($urandom), e, m, af);
    case (o)
      2'b01: begin
        e = '0; m = wmask();
        e.b = 2'b01; m.a = 1'b1; m.b = 2'b11;
        step(PH_MA, 1'($urandom), e, m, af);
        w = pick_wait(fw_mem);
        e = '0; m = wmask();
        e.adr = 1'b1; m.adr = 1'b1;
        if (f[0]) begin
          repeat (w) step(PH_MR, 1'b0, e, m, af);
          step(PH_MR, 1'b1, e, m, af);
          e = '0; m = wmask();
          e.res = 2'b01; m.res = 2'b11;
          e.rw = ce; e.pcw = ce && r == 4'd15;
          step(PH_MWB, 1'($urandom), e, m, af);
        end else begin
          e.mw = ce;
          repeat (w) step(PH_MW, 1'b0, e, m, af);
          step(PH_MW, 1'b1, e, m, af);
        end
      end
      2'b10: begin
        e = '0; m = wmask();
        e.b = 2'b01; e.res = 2'b10; e.pcw = ce;
        m.a = 1'b1; m.b = 2'b11; m.res = 2'b11;
        step(PH_BR, 1'($urandom), e, m, af);
      end
      2'b00: begin
        e = '0; m = wmask();
        e.b = f[5] ? 2'b01 : 2'b00;
        e.alu = alu;
        e.shs = is_mov || is_mvn;
        e.movs = is_mov && f[5];
        e.mvns = is_mvn && f[5];
        m.b = 2'b11; m.shs = 1'b1;
        m.movs = 1'b1; m.mvns = 1'b1;
        step(PH_EX, 1'($urandom), e, m, af);
        if (!aborted && ce && f[0]) begin
          flags_m[3:2] = af[3:2];
          if (!alu[3]) flags_m[1:0] = af[1:0];
        end
        e = '0; m = wmask();
        m.res = 2'b11;
        e.rw = ce && !nw;
        e.pcw = ce && !nw && r == 4'd15;
        step(PH_AWB, 1'($urandom), e, m, af);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_chk++;
      if ((obs & x.m) !== (x.e & x.m)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h (mask %h)",
                 ph_name(x.ph), cyc, obs & x.m, x.e & x.m, x.m);
      end
    end
  end

  initial begin
    item_t it;
    exp_t x;
    cur = '{default: '0};
    push_rst();
    push_rst();
    // ADDS R1, imm
    fw_fetch = 0; fw_mem = 3;
    run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 2'b00, -1);
    // LDR with three wait cycles in memread
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 2'b00, -1);
    fw_mem = 0;
    push_rst();
    // BEQ with Z clear, then CMP sets Z, BEQ taken
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 2'b00, -1);
    force_af = 4'b0100;
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 2'b00, -1);
    force_af = -1;
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 2'b00, -1);
    // MOVEQ R15, imm
    run_instr(4'b0000, 2'b00, 6'b111010, 4'd15, 2'b00, -1);
    // STR aborted by reset inside memwrite
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 2'b00, 3);
    // LSRS leaves C/V untouched; BCS not taken, BEQ taken
    push_rst();
    force_af = 4'b1111;
    run_instr(4'b1110, 2'b00, 6'b011011, 4'd4, 2'b01, -1);
    force_af = -1;
    run_instr(4'b0010, 2'b10, 6'b000000, 4'd0, 2'b00, -1);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 2'b00, -1);
    fw_fetch = -1; fw_mem = -1;
    for (int i = 0; i < 400; i++) begin
      run_instr(4'($urandom), 2'($urandom), 6'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                2'($urandom),
                ($urandom_range(0, 9) == 0) ?
                  int'($urandom_range(0, 6)) : -1);
    end
    while (plan.size() > 0) begin
      it = plan.pop_front();
      @(posedge clk);
      #1;
      cyc++;
      reset = it.rst;
      cond = it.cond;
      op = it.op;
      funct = it.funct;
      rd = it.rd;
      sh = it.sh;
      alu_flags = it.af;
      mem_ready = it.rdy;
      x.e = it.e;
      x.m = it.m;
      x.ph = it.ph;
      sb.push_back(x);
    end
    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
